rs_latch_arbiter: RTL

- Shares one NAND-style RS latch (active-low set/reset inputs notS/notR, output Q) between N_REQ requesters.
- Each requester asks to set or clear the latch. The block round-robin arbitrates among them and drives a timed active-low pulse on exactly one of notS/notR.
- It guarantees notS and notR are never low together (the forbidden latch input), enforces a recovery gap between pulses, and checks the latch's Q after each operation.
- It sits between the control logic and the bare latch cell.

---
 rtl/rs_latch_pkg.sv | 25 ++
 rtl/rs_latch_arbiter_rr_pick.sv | 27 ++
 rtl/rs_latch_arbiter.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/rs_latch_pkg.sv
// Shared types and defaults for the RS latch arbiter slice.
// Any block that arbitrates access to a bare set/reset latch imports this.
package rs_latch_pkg;

  typedef enum logic [1:0] {
    IDLE,
    PULSE,
    RECOVER,
    CHECK
  } latchStateT;

  typedef enum logic {
    OP_SET,
    OP_CLR
  } latchOpT;

  localparam int unsigned DEF_N_REQ        = 4;
  localparam int unsigned DEF_PULSE_CYCLES = 2;
  localparam int unsigned DEF_GAP_CYCLES   = 2;

  function automatic int unsigned maxOf(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/rs_latch_arbiter_rr_pick.sv
// Combinational round-robin picker: first eligible index at or after ptr,
// wrapping modulo N. Reusable by any arbiter holding its own pointer.
module rr_pick #(
  parameter int unsigned N  = 4,
  parameter int unsigned PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  eligible,
  input  logic [PW-1:0] ptr,
  output logic          valid,
  output logic [PW-1:0] idx
);

  always_comb begin
    logic [PW-1:0] pos;
    valid = 1'b0;
    idx   = '0;
    pos   = '0;
    for (int unsigned off = 0; off < N; off++) begin
      pos = PW'((32'(ptr) + off) % N);
      if (!valid && eligible[pos]) begin
        valid = 1'b1;
        idx   = pos;
      end
    end
  end

endmodule

// File: rtl/rs_latch_arbiter.sv
// Round-robin arbiter driving timed active-low set/clear pulses onto a shared
// NAND RS latch, with a recovery gap and a synchronized check of the latch output.
module rs_latch_arbiter
  import rs_latch_pkg::*;
#(
  parameter int unsigned N_REQ        = DEF_N_REQ,
  parameter int unsigned PULSE_CYCLES = DEF_PULSE_CYCLES,
  parameter int unsigned GAP_CYCLES   = DEF_GAP_CYCLES
) (
  input  logic             clk,
  input  logic             notReset,
  input  logic [N_REQ-1:0] reqSet,
  input  logic [N_REQ-1:0] reqClr,
  output logic [N_REQ-1:0] grant,
  output logic             done,
  output logic             err,
  output logic             badReq,
  output logic             busy,
  output logic             notS,
  output logic             notR,
  input  logic             Q
);

  localparam int unsigned PTR_W = $clog2(N_REQ);
  localparam int unsigned CNT_W = $clog2(maxOf(PULSE_CYCLES, GAP_CYCLES) + 1);
  localparam logic [N_REQ-1:0] GRANT_LSB = N_REQ'(1);

  latchStateT       state, stateNext;
  logic [CNT_W-1:0] cnt, cntNext;
  logic [PTR_W-1:0] ptr, opIdx, pickIdx;
  latchOpT          op;
  logic             pending, pickValid;
  logic             qSync1, qSync2;
  logic [N_REQ-1:0] eligible;

  logic [N_REQ-1:0] grantNext;
  logic             doneNext, errNext, badReqNext, busyNext, notSNext, notRNext;

  assign eligible = reqSet ^ reqClr;

  rr_pick #(
    .N  (N_REQ),
    .PW (PTR_W)
  ) picker (
    .eligible (eligible),
    .ptr      (ptr),
    .valid    (pickValid),
    .idx      (pickIdx)
  );

  always_ff @(posedge clk or negedge notReset) begin
    if (!notReset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= stateNext;
      cnt   <= cntNext;
    end
  end

  // IDLE spends one cycle registering the pick; the grant cycle follows it.
  always_ff @(posedge clk or negedge notReset) begin
    if (!notReset) begin
      pending <= 1'b0;
      opIdx   <= '0;
      op      <= OP_SET;
      ptr     <= '0;
      qSync1  <= 1'b0;
      qSync2  <= 1'b0;
    end else begin
      qSync1 <= Q;
      qSync2 <= qSync1;
      if (state == IDLE) begin
        if (pending) begin
          pending <= 1'b0;
        end else if (pickValid) begin
          pending <= 1'b1;
          opIdx   <= pickIdx;
          op      <= reqSet[pickIdx] ? OP_SET : OP_CLR;
        end
      end
      if (state == CHECK) begin
        ptr <= (opIdx == PTR_W'(N_REQ - 1)) ? '0 : opIdx + PTR_W'(1);
      end
    end
  end

  always_comb begin
    stateNext = state;
    cntNext   = cnt;
    unique case (state)
      IDLE: begin
        if (pending) begin
          stateNext = PULSE;
          cntNext   = CNT_W'(1);
        end
      end
      PULSE: begin
        if (cnt == CNT_W'(PULSE_CYCLES)) begin
          stateNext = RECOVER;
          cntNext   = CNT_W'(1);
        end else begin
          cntNext = cnt + CNT_W'(1);
        end
      end
      RECOVER: begin
        if (cnt == CNT_W'(GAP_CYCLES)) begin
          stateNext = CHECK;
          cntNext   = '0;
        end else begin
          cntNext = cnt + CNT_W'(1);
        end
      end
      CHECK: begin
        stateNext = IDLE;
        cntNext   = '0;
      end
      default: begin
        stateNext = IDLE;
        cntNext   = '0;
      end
    endcase
  end

  // op is a single bit, so at most one of the latch inputs can go low.
  always_comb begin
    grantNext  = '0;
    if (state == IDLE && pending) grantNext = GRANT_LSB << opIdx;
    notSNext   = !(stateNext == PULSE && op == OP_SET);
    notRNext   = !(stateNext == PULSE && op == OP_CLR);
    doneNext   = (state == CHECK);
    errNext    = (state == CHECK) && (qSync2 != (op == OP_SET));
    badReqNext = (state == IDLE) && |(reqSet & reqClr);
    busyNext   = (stateNext != IDLE);
  end

  always_ff @(posedge clk or negedge notReset) begin
    if (!notReset) begin
      grant  <= '0;
      done   <= 1'b0;
      err    <= 1'b0;
      badReq <= 1'b0;
      busy   <= 1'b0;
      notS   <= 1'b1;
      notR   <= 1'b1;
    end else begin
      grant  <= grantNext;
      done   <= doneNext;
      err    <= errNext;
      badReq <= badReqNext;
      busy   <= busyNext;
      notS   <= notSNext;
      notR   <= notRNext;
    end
  end

endmodule
